quad_encoder_if: RTL and testbench
==================================

Name: quad_encoder_if

Overview:
Quadrature encoder front-end for the motor-control path; it consumes the two raw encoder channels arriving from GPIO.
- Synchronises and glitch-filters the A/B pair.
- Decodes x4 quadrature steps into a signed position count.
- Measures velocity as the count delta over a fixed sample window.
- Exposes position, velocity, status and control to the Nios II as an Avalon-MM slave component.

Parameters:
CNT_W, 32, position/velocity register width (bits, signed two's complement).
FILT_LEN, 4, consecutive identical synchronised samples required before the filtered A/B value updates (>=1).
VEL_PERIOD, 50000, velocity sample window in clk cycles (1 ms at 50 MHz, >=2).

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  synchronous, active-high reset.
enc_a  in  1  raw encoder channel A, asynchronous.
enc_b  in  1  raw encoder channel B, asynchronous.
avs_address  in  2  word address: 0 POSITION, 1 VELOCITY, 2 STATUS, 3 CTRL.
avs_read  in  1  read strobe.
avs_write  in  1  write strobe.
avs_writedata  in  32  write data.
avs_readdata  out  32  read data, registered, read latency 1.

Behaviour:
- Reset values:
  - position 0, velocity 0, window sample 0, period counter 0.
  - STATUS 0; CTRL = 0x1 (enable=1, invert=0).
  - avs_readdata 0.
  - Sync/filter registers 0; previous-state register 00.
- Synchronisation: 2-FF synchroniser per channel.
- Filter: per-pair stability counter.
  - Synchronised {A,B} differing from the candidate value: candidate <= new value, counter <= 1.
  - Otherwise counter increments, saturating at FILT_LEN.
  - Filtered {A,B} <= candidate in the cycle the counter reaches FILT_LEN.
  - Pulses shorter than FILT_LEN cycles never reach the decoder.
- Decoder: compares filtered {A,B} with the previous-state register each cycle; previous <= filtered every cycle.
  - Forward sequence 00->01->11->10->00: step +1.
  - Reverse sequence: step -1.
  - No change: 0.
  - Both bits changed: illegal. No count; STATUS.err (bit0) set sticky.
  - CTRL.invert (bit1) negates the step sign.
- Latency: an input edge that is stable at the enc_a/enc_b pins yields a position change 2+FILT_LEN+1 clk cycles after the first clk edge that samples it.
- Position: CNT_W-bit signed, wraps modulo 2^CNT_W; 0x7FFFFFFF +1 -> 0x80000000, and the reverse. No saturation.
- Enable:
  - CTRL.enable=0: position holds and steps are discarded.
  - Sync, filter and previous-state keep tracking, so re-enabling produces no spurious step.
  - The velocity window keeps running.
- Velocity:
  - Period counter runs 0..VEL_PERIOD-1.
  - At terminal count: velocity <= position - window_sample (modular subtraction); window_sample <= position; counter <= 0.
  - STATUS.dir (bit1) <= 1 if the last nonzero step was negative (updated per step).
- Register writes:
  - POSITION write loads avs_writedata next cycle.
  - A write and a decoded step in the same cycle: the write wins and the step is dropped.
  - Writing POSITION also sets window_sample <= writedata, so the next velocity is not corrupted.
  - VELOCITY: writes ignored.
  - STATUS: bit0 is write-1-to-clear. If set and clear coincide in one cycle, set wins.
  - CTRL: bits[1:0] writable; upper bits read 0.
- Reads: avs_readdata <= selected register on the cycle after avs_read. Unread cycles hold the last value.
- Simultaneous read and write at the same address: read returns the pre-write value.
- Reset asserted mid-operation: all state returns to reset values on the next clk edge; the filter requires FILT_LEN fresh samples afterwards.

Decomposition:
- Package quad_encoder_pkg:
  - register address constants (ADDR_POSITION=0, ADDR_VELOCITY=1, ADDR_STATUS=2, ADDR_CTRL=3).
  - STATUS/CTRL bit indices.
  - typedef enum for step result (STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR).
- One sub-module: quad_input_filter.
  - Instantiated once per channel pair.
  - Contains the synchroniser plus stability counter; outputs the filtered 2-bit state.
- Decoder, counters and the Avalon register file live in the top block.

Test Plan:
- Forward drive: 8 forward steps, each phase held 10 cycles -> POSITION reads 8; STATUS.dir=0; first increment occurs exactly 2+FILT_LEN+1 cycles after the first edge.
- Glitch rejection: a 3-cycle pulse on A with FILT_LEN=4 -> POSITION unchanged, STATUS.err=0. Then a 5-cycle pulse -> +1 followed by -1, net 0.
- Illegal transition: A and B toggled together 00->11 -> POSITION unchanged, STATUS=0x1. Write STATUS=0x1 -> reads 0x0.
- Wrap and invert: write POSITION=0x7FFFFFFF, one forward step -> 0x80000000. Set CTRL=0x3, one forward step -> 0x7FFFFFFF, STATUS.dir=1.
- Velocity: VEL_PERIOD=100; 25 forward steps inside one window -> VELOCITY=25 after the window boundary. Next window with 10 reverse steps -> VELOCITY=0xFFFFFFF6.
- Collision and enable:
  - POSITION write of 100 in the same cycle as a decoded step -> reads 100.
  - CTRL.enable=0 with 5 steps -> unchanged; re-enable -> no spurious step.
  - Synchronous reset mid-stream -> all registers read reset values.

Source files
------------

// File: rtl/quad_encoder_pkg.sv
// rtl/quad_encoder_pkg.sv - register map, bit indices and step decode for the encoder front-end
package quad_encoder_pkg;

  localparam logic [1:0] ADDR_POSITION = 2'd0;
  localparam logic [1:0] ADDR_VELOCITY = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_DIR_BIT = 1;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_INV_BIT   = 1;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00, states written as {A,B}.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur) return STEP_NONE;
    if ((prev ^ cur) == 2'b11) return STEP_ERR;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_FWD;
      default: return STEP_REV;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - 2-FF synchroniser and stability filter for the A/B pair
module quad_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] filt
);

  localparam int CNT_BITS = $clog2(FILT_LEN + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(FILT_LEN);

  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          cand;
  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      cand  <= 2'b00;
      cnt   <= '0;
      filt  <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CNT_BITS'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_BITS'(1);
      end
      // A candidate that has collected FILT_LEN matching samples is committed.
      if (cnt == CNT_MAX) filt <= cand;
    end
  end

endmodule

// File: rtl/quad_encoder_if.sv
// rtl/quad_encoder_if.sv - x4 quadrature decoder with position/velocity registers on Avalon-MM
module quad_encoder_if
  import quad_encoder_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int VEL_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int PER_W = $clog2(VEL_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(VEL_PERIOD - 1);

  logic [1:0]              filt_ab;
  logic [1:0]              prev_ab;
  logic signed [CNT_W-1:0] position;
  logic signed [CNT_W-1:0] velocity;
  logic signed [CNT_W-1:0] window_sample;
  logic signed [CNT_W-1:0] delta;
  logic [PER_W-1:0]        per_cnt;
  logic                    err;
  logic                    dir;
  logic [1:0]              ctrl;
  step_t                   step;
  logic                    counted;
  logic                    neg;
  logic                    pos_wr;
  logic                    status_wr;
  logic                    ctrl_wr;
  logic [31:0]             rd_mux;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk   (clk),
    .reset (reset),
    .raw   ({enc_a, enc_b}),
    .filt  (filt_ab)
  );

  always_comb begin
    step      = decode_step(prev_ab, filt_ab);
    counted   = ctrl[CTRL_EN_BIT] && (step == STEP_FWD || step == STEP_REV);
    neg       = (step == STEP_REV) ^ ctrl[CTRL_INV_BIT];
    delta     = neg ? {CNT_W{1'b1}} : CNT_W'(1);
    pos_wr    = avs_write && (avs_address == ADDR_POSITION);
    status_wr = avs_write && (avs_address == ADDR_STATUS);
    ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab       <= 2'b00;
      position      <= '0;
      velocity      <= '0;
      window_sample <= '0;
      per_cnt       <= '0;
      err           <= 1'b0;
      dir           <= 1'b0;
      ctrl          <= 2'b01;
    end else begin
      prev_ab <= filt_ab;
      // A host load takes priority over a step decoded in the same cycle.
      if (pos_wr) position <= CNT_W'(avs_writedata);
      else if (counted) position <= position + delta;
      if (counted) dir <= neg;
      err <= (step == STEP_ERR) | (err & ~(status_wr & avs_writedata[STATUS_ERR_BIT]));
      if (ctrl_wr) ctrl <= avs_writedata[1:0];
      if (per_cnt == PER_LAST) begin
        per_cnt       <= '0;
        velocity      <= position - window_sample;
        window_sample <= position;
      end else begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      // Rebase the window on a position load so the next delta is not polluted.
      if (pos_wr) window_sample <= CNT_W'(avs_writedata);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_POSITION: rd_mux = 32'(position);
      ADDR_VELOCITY: rd_mux = 32'(velocity);
      ADDR_STATUS: begin
        rd_mux[STATUS_ERR_BIT] = err;
        rd_mux[STATUS_DIR_BIT] = dir;
      end
      default: rd_mux[1:0] = ctrl;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_quad_encoder_if.sv
// tb/tb_quad_encoder_if.sv - directed self-checking bench for quad_encoder_if
module tb_quad_encoder_if;

  logic        clk;
  logic        reset;
  logic        enc_a;
  logic        enc_b;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int idx = 0;

  quad_encoder_if #(.CNT_W(32), .FILT_LEN(4), .VEL_PERIOD(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset released; equals the DUT velocity period counter.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    avs_address = a;
    avs_writedata = data;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic step(input int d, input int hold);
    idx = (idx + d) & 3;
    {enc_a, enc_b} = gray(idx);
    tick(hold);
  endtask

  // Pins change now; the register write lands on the edge where the decoder acts.
  task automatic collide(input logic [1:0] pins, input logic [1:0] a, input logic [31:0] data);
    {enc_a, enc_b} = pins;
    tick(7);
    wr(a, data);
    tick(15);
  endtask

  task automatic wait_cyc(input int m);
    chk("align", 32'(cyc <= m), 32'd1);
    while (cyc < m) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    {enc_a, enc_b} = 2'b00;
    avs_address = 2'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    tick(3);
    reset = 1'b0;

    chk("rst_readdata", avs_readdata, 32'h0);
    chk_rd("rst_position", 2'd0, 32'h0);
    chk_rd("rst_velocity", 2'd1, 32'h0);
    chk_rd("rst_status", 2'd2, 32'h0);
    chk_rd("rst_ctrl", 2'd3, 32'h1);

    // 25 forward steps land on edges 101..197, inside the window closing at edge 200.
    wait_cyc(93);
    for (int i = 0; i < 25; i++) step(1, 4);
    wait_cyc(195);
    for (int i = 0; i < 10; i++) step(-1, 4);
    tick(10);
    chk_rd("vel_fwd", 2'd1, 32'd25);
    chk_rd("vel_pos", 2'd0, 32'd15);
    chk_rd("vel_status_dir", 2'd2, 32'h2);
    wait_cyc(305);
    chk_rd("vel_rev", 2'd1, 32'hFFFF_FFF6);

    wr(2'd0, 32'd0);
    idx = (idx + 1) & 3;
    {enc_a, enc_b} = gray(idx);
    avs_address = 2'd0;
    avs_read = 1'b1;
    tick(8);
    chk("latency_before", avs_readdata, 32'd0);
    tick(1);
    chk("latency_at", avs_readdata, 32'd1);
    avs_read = 1'b0;
    tick(1);
    for (int i = 0; i < 7; i++) step(1, 10);
    chk_rd("fwd8_position", 2'd0, 32'd8);
    chk_rd("fwd8_status", 2'd2, 32'h0);

    enc_a = ~enc_a;
    tick(3);
    enc_a = ~enc_a;
    tick(20);
    chk_rd("glitch3_position", 2'd0, 32'd8);
    chk_rd("glitch3_status", 2'd2, 32'h0);
    enc_a = ~enc_a;
    tick(5);
    enc_a = ~enc_a;
    tick(20);
    chk_rd("glitch5_position", 2'd0, 32'd8);
    chk_rd("glitch5_status", 2'd2, 32'h2);

    step(1, 20);
    idx = 2;
    {enc_a, enc_b} = 2'b11;
    tick(20);
    chk_rd("illegal_position", 2'd0, 32'd9);
    chk_rd("illegal_status", 2'd2, 32'h1);
    wr(2'd2, 32'h1);
    chk_rd("err_cleared", 2'd2, 32'h0);
    collide(2'b00, 2'd2, 32'h1);
    idx = 0;
    chk_rd("err_set_wins", 2'd2, 32'h1);
    chk_rd("illegal2_position", 2'd0, 32'd9);
    wr(2'd2, 32'h1);
    chk_rd("err_cleared2", 2'd2, 32'h0);

    wr(2'd0, 32'h7FFF_FFFF);
    step(1, 20);
    chk_rd("wrap_up", 2'd0, 32'h8000_0000);
    wr(2'd3, 32'h3);
    step(1, 20);
    chk_rd("invert_position", 2'd0, 32'h7FFF_FFFF);
    chk_rd("invert_status", 2'd2, 32'h2);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd("ctrl_mask", 2'd3, 32'h3);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h8000_0000);
    step(-1, 20);
    chk_rd("wrap_down", 2'd0, 32'h7FFF_FFFF);

    idx = (idx + 1) & 3;
    collide(gray(idx), 2'd0, 32'd100);
    chk_rd("collision_write_wins", 2'd0, 32'd100);
    avs_address = 2'd0;
    avs_writedata = 32'd5;
    avs_read = 1'b1;
    avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    avs_write = 1'b0;
    chk("rw_same_cycle_old", avs_readdata, 32'd100);
    chk_rd("rw_same_cycle_new", 2'd0, 32'd5);

    wr(2'd3, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 10);
    chk_rd("disabled_hold", 2'd0, 32'd5);
    wr(2'd3, 32'h1);
    tick(20);
    chk_rd("reenable_no_spurious", 2'd0, 32'd5);
    step(1, 20);
    chk_rd("reenable_counts", 2'd0, 32'd6);

    step(-1, 20);
    wr(2'd3, 32'h2);
    chk_rd("pre_reset_position", 2'd0, 32'd5);
    step(1, 2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("mid_rst_readdata", avs_readdata, 32'h0);
    chk_rd("mid_rst_position", 2'd0, 32'h0);
    chk_rd("mid_rst_velocity", 2'd1, 32'h0);
    chk_rd("mid_rst_status", 2'd2, 32'h0);
    chk_rd("mid_rst_ctrl", 2'd3, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
